c64_cia_timer: RTL and testbench
================================

Name: c64_cia_timer

Overview:
- CIA-style interval timer pair: Timer A and Timer B, 16-bit down-counters with latches, an interrupt control register and an IRQ output.
- Sits on the 6502 bus beside the processor-port GPIO and ROM/RAM decode. It drives the CPU IRQ input, which is currently tied low.
- Its read data is muxed into the CPU data-in path with the same one-cycle registered-read latency used by the other peripherals.

Parameters:
- TICK_DIV, 50: clk cycles per timer tick (phi2 equivalent). Value 1 means a tick every clk. Legal values are 1..65535.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-low; the block is in reset when reset==0 at posedge clk.
- cs, input, 1: chip select from the address decoder.
- addr, input, 4: register select (CPU address [3:0]).
- DI, input, 8: write data (CPU DO).
- WE, input, 1: write enable; a write happens when cs&WE.
- DO, output, 8: registered read data; valid the cycle after cs&!WE.
- irq, output, 1: active-high interrupt request to the CPU.

Behaviour:
- Reset values: DO=0, irq=0, both counters=16'hFFFF, both latches=16'hFFFF, ICR flags=0, ICR mask=0, CRA=0, CRB=0, prescaler=0.
- Prescaler: counts 0..TICK_DIV-1. tick=1 for one clk when prescaler==TICK_DIV-1, then prescaler wraps to 0.
- Register map (unlisted addresses read 0, writes ignored):
  - 0x4 TA_LO / 0x5 TA_HI: write sets the latch byte; read returns the live counter byte.
  - 0x6 TB_LO / 0x7 TB_HI: same, for Timer B.
  - 0xD ICR: described below.
  - 0xE CRA: bit0 START, bit3 ONESHOT, bit4 LOAD.
  - 0xF CRB: bit0 START, bit3 ONESHOT, bit4 LOAD, bit6 INMODE.
  - CR bits 1,2,5,7 are stored and read back. LOAD is a strobe and always reads 0.
- Latch-HI write while that timer is stopped (START==0): the counter is also loaded with the full new latch value on the same edge.
- LOAD strobe: the counter is loaded from the latch on the write edge. The LOAD value takes priority over any decrement or underflow that cycle.
- Count events:
  - Timer A counts on tick.
  - Timer B counts on tick when INMODE=0, or on a Timer A underflow in the same cycle when INMODE=1.
- When a timer with START=1 receives a count event:
  - If counter!=0, the counter decrements by 1.
  - If counter==0, the timer underflows: counter reloads from the latch, the flag (A=ICR bit0, B=ICR bit1) is set, and if ONESHOT=1 then START clears.
  - Period is therefore latch+1 events. A latch of 0 underflows on every event.
- ICR write: DI[7]=1 sets mask bits where DI[1:0]==1. DI[7]=0 clears mask bits where DI[1:0]==1.
- ICR read returns {irq_pending, 5'b0, flagB, flagA}, where irq_pending=|(flags&mask). On that same edge both flags clear.
- If an underflow and an ICR read happen in the same cycle, the set wins: the flag stays 1 and the read returns the old value.
- irq is registered: irq <= |(next_flags & mask). It deasserts the cycle after the clearing ICR read.
- Read path: DO <= reg[addr] at the posedge when cs&!WE, otherwise DO holds. Counter reads return the value before that edge's decrement.
- Reset asserted mid-count: all state returns to reset values on that edge; no underflow or flag is produced.
- Writes with cs=0 have no effect. ICR side effects occur only on cs&!WE with addr==0xD.

Optional Feature:
- Macro CIA_TIMER_PB_EN.
- When defined: adds output ports ta_pulse and tb_pulse, each 1-bit. They are registered, one clk wide, and assert the cycle after the matching underflow. Both reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic A count (TICK_DIV=1):
  - Stimulus: write TA_LO=0x03, TA_HI=0x00, ICR=0x81, CRA=0x01.
  - Response: counter reads 3,2,1,0. Flag A sets on the 4th event after start. irq=1 one cycle later. ICR read returns 0x81, the next ICR read returns 0x00, and irq=0.
- One-shot:
  - Stimulus: latch=0x0002, CRA=0x09.
  - Response: exactly one underflow. CRA reads 0x08 afterwards. Counter holds at 0x0002 and no further flag is set.
- Cascade:
  - Stimulus: TA latch=0x0001, TB latch=0x0002, CRB=0x41, CRA=0x01.
  - Response: TB decrements once per two ticks. Flag B sets after 6 ticks. With mask=0, irq stays 0 while ICR bit1=1.
- LOAD priority:
  - Stimulus: a running counter at 0x0000, then a write of CRA=0x11 on the same cycle as a tick.
  - Response: counter equals the latch, and no flag A is set.
- Set-wins:
  - Stimulus: an ICR read on the exact underflow cycle.
  - Response: DO shows flag=0 and the flag remains 1. The next ICR read returns bit0=1 and then clears it.
- Reset:
  - Stimulus: reset=0 for one clk during a running count with irq=1.
  - Response: the next cycle shows irq=0, DO=0, and TA_LO/TA_HI reading 0xFF/0xFF. With TICK_DIV=4, the first tick comes 4 clks after reset release.

Source files
------------

// File: rtl/c64_cia_timer.sv
// rtl/c64_cia_timer.sv - CIA-style Timer A/B pair with ICR, IRQ and registered 6502 read path
// Optional macro CIA_TIMER_PB_EN adds registered one-clock ta_pulse/tb_pulse underflow outputs.
module c64_cia_timer #(
  parameter int TICK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [3:0] addr,
  input  logic [7:0] DI,
  input  logic       WE,
  output logic [7:0] DO,
  output logic       irq
`ifdef CIA_TIMER_PB_EN
  ,
  output logic       ta_pulse,
  output logic       tb_pulse
`endif
);

  localparam logic [3:0] A_TA_LO = 4'h4;
  localparam logic [3:0] A_TA_HI = 4'h5;
  localparam logic [3:0] A_TB_LO = 4'h6;
  localparam logic [3:0] A_TB_HI = 4'h7;
  localparam logic [3:0] A_ICR   = 4'hD;
  localparam logic [3:0] A_CRA   = 4'hE;
  localparam logic [3:0] A_CRB   = 4'hF;

  logic [15:0] presc;
  logic        tick;
  logic [15:0] ta_cnt, tb_cnt, ta_latch, tb_latch;
  logic [7:0]  cra, crb;
  logic [1:0]  flags, mask;

  logic        wr, rd, icr_rd;
  logic        ta_load, tb_load;
  logic [15:0] ta_load_val, tb_load_val;
  logic        ta_evt, tb_evt, ta_uf, tb_uf;
  logic [1:0]  flags_next, mask_next;
  logic [7:0]  rdata;

  assign tick   = (presc == 16'(TICK_DIV - 1));
  assign wr     = cs & WE;
  assign rd     = cs & ~WE;
  assign icr_rd = rd && (addr == A_ICR);

  // A LOAD (strobe or stopped HI write) overrides the count event and suppresses underflow.
  always_comb begin
    ta_load     = 1'b0;
    ta_load_val = ta_latch;
    tb_load     = 1'b0;
    tb_load_val = tb_latch;
    if (wr && addr == A_TA_HI && !cra[0]) begin
      ta_load     = 1'b1;
      ta_load_val = {DI, ta_latch[7:0]};
    end
    if (wr && addr == A_CRA && DI[4]) ta_load = 1'b1;
    if (wr && addr == A_TB_HI && !crb[0]) begin
      tb_load     = 1'b1;
      tb_load_val = {DI, tb_latch[7:0]};
    end
    if (wr && addr == A_CRB && DI[4]) tb_load = 1'b1;
  end

  assign ta_evt = cra[0] & tick;
  assign ta_uf  = ta_evt & (ta_cnt == 16'h0000) & ~ta_load;
  assign tb_evt = crb[0] & (crb[6] ? ta_uf : tick);
  assign tb_uf  = tb_evt & (tb_cnt == 16'h0000) & ~tb_load;

  // An underflow landing on the clearing ICR read keeps its flag set.
  assign flags_next = (flags & ~{2{icr_rd}}) | {tb_uf, ta_uf};

  always_comb begin
    mask_next = mask;
    if (wr && addr == A_ICR) begin
      if (DI[7]) mask_next = mask | DI[1:0];
      else       mask_next = mask & ~DI[1:0];
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      A_TA_LO: rdata = ta_cnt[7:0];
      A_TA_HI: rdata = ta_cnt[15:8];
      A_TB_LO: rdata = tb_cnt[7:0];
      A_TB_HI: rdata = tb_cnt[15:8];
      A_ICR:   rdata = {|(flags & mask), 5'b00000, flags};
      A_CRA:   rdata = cra;
      A_CRB:   rdata = crb;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc    <= 16'h0000;
      ta_cnt   <= 16'hFFFF;
      tb_cnt   <= 16'hFFFF;
      ta_latch <= 16'hFFFF;
      tb_latch <= 16'hFFFF;
      cra      <= 8'h00;
      crb      <= 8'h00;
      flags    <= 2'b00;
      mask     <= 2'b00;
      irq      <= 1'b0;
      DO       <= 8'h00;
    end else begin
      presc <= tick ? 16'h0000 : presc + 16'd1;

      if (wr && addr == A_TA_LO) ta_latch[7:0]  <= DI;
      if (wr && addr == A_TA_HI) ta_latch[15:8] <= DI;
      if (wr && addr == A_TB_LO) tb_latch[7:0]  <= DI;
      if (wr && addr == A_TB_HI) tb_latch[15:8] <= DI;

      if (ta_load)     ta_cnt <= ta_load_val;
      else if (ta_evt) ta_cnt <= (ta_cnt == 16'h0000) ? ta_latch : ta_cnt - 16'd1;
      if (tb_load)     tb_cnt <= tb_load_val;
      else if (tb_evt) tb_cnt <= (tb_cnt == 16'h0000) ? tb_latch : tb_cnt - 16'd1;

      // LOAD is a strobe, so bit 4 is never stored.
      if (wr && addr == A_CRA)  cra    <= DI & 8'hEF;
      else if (ta_uf && cra[3]) cra[0] <= 1'b0;
      if (wr && addr == A_CRB)  crb    <= DI & 8'hEF;
      else if (tb_uf && crb[3]) crb[0] <= 1'b0;

      flags <= flags_next;
      mask  <= mask_next;
      irq   <= |(flags_next & mask);

      if (rd) DO <= rdata;
    end
  end

`ifdef CIA_TIMER_PB_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ta_pulse <= 1'b0;
      tb_pulse <= 1'b0;
    end else begin
      ta_pulse <= ta_uf;
      tb_pulse <= tb_uf;
    end
  end
`endif

endmodule

// File: tb/tb_c64_cia_timer.sv
// tb/tb_c64_cia_timer.sv - directed self-checking bench for c64_cia_timer
// Two instances share the bus: TICK_DIV=1 for function, TICK_DIV=4 for prescaler timing.
module tb_c64_cia_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] din = 8'h00;
  logic       we = 1'b0;
  logic [7:0] dout, dout4;
  logic       irq, irq4;
`ifdef CIA_TIMER_PB_EN
  logic       ta_pulse, tb_pulse, ta_pulse4, tb_pulse4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c64_cia_timer #(.TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .DI(din), .WE(we),
    .DO(dout), .irq(irq)
`ifdef CIA_TIMER_PB_EN
    , .ta_pulse(ta_pulse), .tb_pulse(tb_pulse)
`endif
  );

  c64_cia_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .DI(din), .WE(we),
    .DO(dout4), .irq(irq4)
`ifdef CIA_TIMER_PB_EN
    , .ta_pulse(ta_pulse4), .tb_pulse(tb_pulse4)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(2);
    reset = 1'b1;
    chk("rst_do", dout, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_do4", dout4, 8'h00);

    // Basic Timer A count, latch 3
    wr(4'h4, 8'h03); wr(4'h5, 8'h00); wr(4'hD, 8'h81); wr(4'hE, 8'h01);
    rd(4'h4); chk("a_cnt3", dout, 8'h03);
    rd(4'h4); chk("a_cnt2", dout, 8'h02);
    rd(4'h4); chk("a_cnt1", dout, 8'h01);
    chk("a_irq_pre", {7'b0, irq}, 8'h00);
    rd(4'h4); chk("a_cnt0", dout, 8'h00);
    chk("a_irq_set", {7'b0, irq}, 8'h01);
`ifdef CIA_TIMER_PB_EN
    chk("a_pulse", {7'b0, ta_pulse}, 8'h01);
`endif
    rd(4'hD); chk("a_icr1", dout, 8'h81);
    chk("a_irq_clr", {7'b0, irq}, 8'h00);
    rd(4'hD); chk("a_icr2", dout, 8'h00);
    chk("a_irq_low", {7'b0, irq}, 8'h00);
    wr(4'hE, 8'h00); wr(4'hD, 8'h01);

    // One-shot, latch 2
    wr(4'h4, 8'h02); wr(4'h5, 8'h00); wr(4'hE, 8'h09);
    idle(6);
    rd(4'hE); chk("os_cra", dout, 8'h08);
    rd(4'hD); chk("os_icr1", dout, 8'h01);
    idle(4);
    rd(4'hD); chk("os_icr2", dout, 8'h00);
    rd(4'h4); chk("os_lo", dout, 8'h02);
    rd(4'h5); chk("os_hi", dout, 8'h00);

    // Cascade: TB counts Timer A underflows
    wr(4'h4, 8'h01); wr(4'h5, 8'h00); wr(4'h6, 8'h02); wr(4'h7, 8'h00);
    wr(4'hF, 8'h41); wr(4'hE, 8'h01);
    rd(4'h6); chk("cas_t1", dout, 8'h02);
    rd(4'h6); chk("cas_t2", dout, 8'h02);
    rd(4'h6); chk("cas_t3", dout, 8'h01);
    rd(4'h6); chk("cas_t4", dout, 8'h01);
    rd(4'h6); chk("cas_t5", dout, 8'h00);
    rd(4'h6); chk("cas_t6", dout, 8'h00);
    chk("cas_irq", {7'b0, irq}, 8'h00);
    rd(4'hD); chk("cas_icr", dout, 8'h03);
    chk("cas_irq2", {7'b0, irq}, 8'h00);
    wr(4'hE, 8'h00); wr(4'hF, 8'h00); rd(4'hD);

    // LOAD strobe on the zero-count tick, then ICR read on the underflow edge
    wr(4'h4, 8'h03); wr(4'h5, 8'h00); wr(4'hE, 8'h01);
    idle(3);
    wr(4'hE, 8'h11);
    rd(4'h4); chk("ld_cnt", dout, 8'h03);
    rd(4'hE); chk("ld_cra", dout, 8'h01);
    rd(4'hD); chk("ld_noflag", dout, 8'h00);
    rd(4'hD); chk("sw_old", dout, 8'h00);
    rd(4'hD); chk("sw_kept", dout, 8'h01);
    rd(4'hD); chk("sw_clr", dout, 8'h00);

    // Reset during a running count with irq high
    wr(4'hD, 8'h81);
    idle(1);
    chk("rs_irq_pre", {7'b0, irq}, 8'h01);
    rd(4'hE); chk("rs_do_pre", dout, 8'h01);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk("rs_irq", {7'b0, irq}, 8'h00);
    chk("rs_do", dout, 8'h00);
    cs = 1'b0; we = 1'b1; addr = 4'h5; din = 8'h12;
    idle(1);
    we = 1'b0;
    rd(4'h4); chk("rs_lo", dout, 8'hFF);
    rd(4'h5); chk("rs_hi_nocs", dout, 8'hFF);
    rd(4'h0); chk("unlisted", dout, 8'h00);
    rd(4'hE); chk("rs_cra", dout, 8'h00);

    // Prescaler phase after reset release (TICK_DIV=4)
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    wr(4'hE, 8'h01);
    rd(4'h4); chk("p4_c2", dout4, 8'hFF);
    rd(4'h4); chk("p4_c3", dout4, 8'hFF);
    rd(4'h4); chk("p4_c4", dout4, 8'hFF);
    rd(4'h4); chk("p4_c5", dout4, 8'hFE);
    idle(3);
    rd(4'h4); chk("p4_c9", dout4, 8'hFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
